// File: rtl/activation_unit.sv
// Two-stage pipelined fixed-point activation unit.
// Stage 1 captures the operand, its mode and the clamp comparisons; stage 2
// holds the selected result and a flag telling whether the result differs
// from the operand. Standard valid/ready handshake on both sides.
module activation_unit #(
   parameter int WIDTH      = 32,
   parameter int FRAC       = 15,
   parameter int LEAK_SHIFT = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [1:0]       in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_sat,
   input  logic             clr_count,
   output logic [15:0]      sat_count
);

   localparam logic signed [WIDTH-1:0] ONE  = WIDTH'(1) << FRAC;
   localparam logic signed [WIDTH-1:0] MONE = -ONE;

   // stage 1 state
   logic                    s1_valid_reg;
   logic signed [WIDTH-1:0] s1_x_reg;
   logic [1:0]              s1_mode_reg;
   logic                    s1_neg_reg;
   logic                    s1_gt_one_reg;
   logic                    s1_lt_mone_reg;

   // stage 2 state
   logic                    s2_valid_reg;
   logic [WIDTH-1:0]        out_data_reg;
   logic                    out_sat_reg;
   logic [15:0]             sat_count_reg;

   // handshake
   logic                    in_fire;
   logic                    out_fire;
   logic                    s2_load;

   // comparisons and result selection
   logic signed [WIDTH-1:0] x_in;
   logic signed [WIDTH-1:0] y_next;
   logic                    sat_next;

   assign x_in      = $signed(in_data);
   assign in_ready  = !s1_valid_reg || !s2_valid_reg || out_ready;
   assign in_fire   = in_valid && in_ready;
   assign out_fire  = s2_valid_reg && out_ready;
   // stage 2 accepts stage 1 contents when it is empty or draining this edge
   assign s2_load   = s1_valid_reg && (!s2_valid_reg || out_ready);

   assign out_valid = s2_valid_reg;
   assign out_data  = out_data_reg;
   assign out_sat   = out_sat_reg;
   assign sat_count = sat_count_reg;

   // Stage 1: capture operand, mode and comparison flags on input transfer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg   <= 1'b0;
         s1_x_reg       <= '0;
         s1_mode_reg    <= 2'd0;
         s1_neg_reg     <= 1'b0;
         s1_gt_one_reg  <= 1'b0;
         s1_lt_mone_reg <= 1'b0;
      end else begin
         s1_valid_reg <= in_fire || (s1_valid_reg && !s2_load);
         if (in_fire) begin
            s1_x_reg       <= x_in;
            s1_mode_reg    <= in_mode;
            s1_neg_reg     <= x_in[WIDTH-1];
            s1_gt_one_reg  <= (x_in > ONE);
            s1_lt_mone_reg <= (x_in < MONE);
         end
      end
   end

   // Result selection from the stage 1 flags; leaky shift cannot overflow
   always_comb begin
      y_next = s1_x_reg;
      case (s1_mode_reg)
         2'd0: begin
            if (s1_neg_reg)         y_next = '0;
            else if (s1_gt_one_reg) y_next = ONE;
         end
         2'd1: begin
            if (s1_neg_reg)         y_next = '0;
         end
         2'd2: begin
            if (s1_neg_reg)         y_next = s1_x_reg >>> LEAK_SHIFT;
         end
         default: begin
            if (s1_lt_mone_reg)     y_next = MONE;
            else if (s1_gt_one_reg) y_next = ONE;
         end
      endcase
      sat_next = (y_next != s1_x_reg);
   end

   // Stage 2: result register, held while downstream stalls
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid_reg <= 1'b0;
         out_data_reg <= '0;
         out_sat_reg  <= 1'b0;
      end else begin
         s2_valid_reg <= s2_load || (s2_valid_reg && !out_ready);
         if (s2_load) begin
            out_data_reg <= y_next;
            out_sat_reg  <= sat_next;
         end
      end
   end

   // Saturating count of delivered modified results; clear has priority
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_count_reg <= 16'd0;
      end else if (clr_count) begin
         sat_count_reg <= 16'd0;
      end else if (out_fire && out_sat_reg && (sat_count_reg != 16'hFFFF)) begin
         sat_count_reg <= sat_count_reg + 16'd1;
      end
   end

endmodule

// File: tb/tb_activation_unit.sv
// Directed testbench for activation_unit with hand-computed expected results.
module tb_activation_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_data = '0;
   logic [1:0]  in_mode = 2'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_data;
   logic        out_sat;
   logic        clr_count = 1'b0;
   logic [15:0] sat_count;

   typedef struct {
      logic [31:0] x;
      logic [1:0]  m;
      logic [31:0] y;
      logic        s;
   } vec_t;

   vec_t        vecs[$];
   vec_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          occ = 0;
   logic [15:0] exp_cnt = 16'd0;
   logic [15:0] pat = 16'b1011_0000_0110_1101;
   int          last_cyc;

   activation_unit #(.WIDTH(32), .FRAC(15), .LEAK_SHIFT(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_mode   (in_mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat),
      .clr_count (clr_count),
      .sat_count (sat_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
      checks++;
      if (got !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, expv);
      end
   endtask

   task automatic add(input logic [31:0] x, input logic [1:0] m, input logic [31:0] y, input logic s);
      vec_t v;
      v.x = x; v.m = m; v.y = y; v.s = s;
      vecs.push_back(v);
   endtask

   // Drive vecs through the DUT; ready_mode 0 = always ready, 1 = pattern.
   task automatic run_stream(input int ready_mode, input string name);
      int sent = 0;
      int got = 0;
      int cyc = 0;
      int limit;
      vec_t e;
      limit = vecs.size() * 4 + 20;
      while (got < vecs.size() && cyc < limit) begin
         @(posedge clk); #1;
         out_ready = (ready_mode == 0) ? 1'b1 : pat[cyc % 16];
         in_valid  = (sent < vecs.size());
         if (in_valid) begin
            in_data = vecs[sent].x;
            in_mode = vecs[sent].m;
         end
         #1;
         check({name, " in_ready"}, 32'(in_ready), 32'(!(occ == 2 && !out_ready)));
         if (out_valid && out_ready) begin
            e = exp_q.pop_front();
            check($sformatf("%s y[%0d]", name, got), out_data, e.y);
            check($sformatf("%s sat[%0d]", name, got), 32'(out_sat), 32'(e.s));
            if (e.s && exp_cnt != 16'hFFFF) exp_cnt++;
            got++;
            occ--;
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(vecs[sent]);
            sent++;
            occ++;
         end
         cyc++;
      end
      in_valid = 1'b0;
      if (got < vecs.size()) check({name, " timeout"}, 32'(got), 32'(vecs.size()));
      last_cyc = cyc;
      @(posedge clk); #1;
      check({name, " sat_count"}, 32'(sat_count), 32'(exp_cnt));
      $display("stream %s: %0d words in %0d cycles, sat_count=%0d", name, vecs.size(), cyc, sat_count);
      vecs.delete();
   endtask

   initial begin
      // reset state
      #2 rst_n = 1'b0;
      #2;
      check("rst out_valid", 32'(out_valid), 32'd0);
      check("rst sat_count", 32'(sat_count), 32'd0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post-rst in_ready", 32'(in_ready), 32'd1);
      check("post-rst out_valid", 32'(out_valid), 32'd0);
      check("post-rst out_data", out_data, 32'd0);
      check("post-rst out_sat", 32'(out_sat), 32'd0);

      // hard sigmoid, back-to-back
      add(-5, 0, 0, 1);
      add(0, 0, 0, 0);
      add(16384, 0, 16384, 0);
      add(32768, 0, 32768, 0);
      add(32769, 0, 32768, 1);
      add(32'h7FFFFFFF, 0, 32768, 1);
      run_stream(0, "sigmoid");
      check("sigmoid cycles", 32'(last_cyc), 32'd8);

      // leaky ReLU, ReLU, hard tanh, mixed modes back-to-back
      add(-64, 2, -8, 1);
      add(-1, 2, -1, 0);
      add(32'h80000000, 2, 32'hF0000000, 1);
      add(-64, 1, 0, 1);
      add(-1, 1, 0, 1);
      add(32'h80000000, 1, 0, 1);
      add(32'h7FFFFFFF, 1, 32'h7FFFFFFF, 0);
      add(-40000, 3, -32768, 1);
      add(-32768, 3, -32768, 0);
      add(40000, 3, 32768, 1);
      add(32'h80000000, 3, -32768, 1);
      add(32768, 3, 32768, 0);
      add(0, 2, 0, 0);
      add(32'h80000000, 0, 0, 1);
      run_stream(0, "modes");
      check("modes cycles", 32'(last_cyc), 32'd16);

      // backpressure with a stall pattern including five low cycles
      add(-40000, 3, -32768, 1);
      add(16384, 0, 16384, 0);
      add(-64, 2, -8, 1);
      add(5, 1, 5, 0);
      add(32769, 0, 32768, 1);
      add(32768, 3, 32768, 0);
      add(-9, 2, -2, 1);
      add(-3, 1, 0, 1);
      run_stream(1, "stall");

      // clear
      @(posedge clk); #1 clr_count = 1'b1;
      @(posedge clk); #1 clr_count = 1'b0;
      exp_cnt = 16'd0;
      check("clr sat_count", 32'(sat_count), 32'd0);

      // 65537 saturating outputs: counter sticks at max
      for (int i = 0; i < 65537; i++) add(-1, 1, 0, 1);
      run_stream(0, "satcount");
      check("satcount max", 32'(sat_count), 32'h0000FFFF);

      // single transaction: latency, then clear racing a saturating transfer
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_data = -5; in_mode = 2'd0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      check("lat edge1 out_valid", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check("lat edge2 out_valid", 32'(out_valid), 32'd1);
      check("lat edge2 out_sat", 32'(out_sat), 32'd1);
      clr_count = 1'b1;
      @(posedge clk); #1;
      clr_count = 1'b0;
      check("clr-wins sat_count", 32'(sat_count), 32'd0);
      check("clr-wins out_valid", 32'(out_valid), 32'd0);
      exp_cnt = 16'd0;

      // reset with both stages full and downstream stalled
      add(-5, 0, 0, 1);
      run_stream(0, "pre-reset");
      @(posedge clk); #1;
      out_ready = 1'b0; in_valid = 1'b1; in_data = 100; in_mode = 2'd1;
      @(posedge clk); #1;
      in_data = 200;
      @(posedge clk); #1;
      in_data = 300;
      #1;
      check("full in_ready", 32'(in_ready), 32'd0);
      check("full out_valid", 32'(out_valid), 32'd1);
      check("full out_data", out_data, 32'd100);
      rst_n = 1'b0;
      #1;
      check("async rst out_valid", 32'(out_valid), 32'd0);
      check("async rst sat_count", 32'(sat_count), 32'd0);
      check("async rst out_data", out_data, 32'd0);
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk); #1;
         check($sformatf("no stale out_valid %0d", i), 32'(out_valid), 32'd0);
      end
      check("post-release in_ready", 32'(in_ready), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
